// File: rtl/xpsr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// xpsr_wr_ctrl
//
// Write-side controller that sits directly in front of the xPSR register.
// Each cycle it takes ALU flag updates, MSR writes, exception entry/return
// requests and instruction-retire events. From these it produces at most one
// registered command on the register's set_data / en_* / inst_valid inputs.
//
// The xPSR register advances its IT state only in cycles where no enable is
// asserted. A retire that collides with a write is therefore counted in a
// small deferred-retire counter and replayed as an inst_valid pulse in a later
// write-free cycle. An exception entry or return flushes the counter.
//
// Ports
//   clk, rst_n          core clock, synchronous active-low reset
//   alu_valid/flags/mask/ready    ALU flag update {N,Z,C,V,Q}
//   msr_valid/data/mask/ready     MSR write, mask = {apsr, ipsr, epsr}
//   exc_ent_valid, exc_num, cur_epsr   exception entry
//   exc_ret_valid, stacked_psr         exception return
//   exc_ready                     entry/return accepted (combinational)
//   exc_done                      pulse in the bubble cycle after an exception
//   retire, retire_ready          instruction retire handshake
//   set_data, en_apsr, en_ipsr, en_epsr, inst_valid   registered command
// -----------------------------------------------------------------------------
module xpsr_wr_ctrl #(
    parameter int unsigned PEND_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_flags,
    input  logic [4:0]  alu_mask,
    output logic        alu_ready,
    input  logic        msr_valid,
    input  logic [31:0] msr_data,
    input  logic [2:0]  msr_mask,
    output logic        msr_ready,
    input  logic        exc_ent_valid,
    input  logic [8:0]  exc_num,
    input  logic [9:0]  cur_epsr,
    input  logic        exc_ret_valid,
    input  logic [31:0] stacked_psr,
    output logic        exc_ready,
    output logic        exc_done,
    input  logic        retire,
    output logic        retire_ready,
    output logic [31:0] set_data,
    output logic [4:0]  en_apsr,
    output logic        en_ipsr,
    output logic        en_epsr,
    output logic        inst_valid
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_EXC_BUB = 1'b1
    } state_t;

    localparam logic [1:0] PEND_MAX_C = 2'(PEND_MAX);

    // Build the xPSR image written on exception entry. cur_epsr is laid out as
    // {IT[1:0], T, ICI/IT[5:0], a}. Only T (bit 24) and the alignment bit
    // (bit 9) survive; the IT/ICI fields are cleared by writing zeros.
    function automatic logic [31:0] entry_image(input logic [8:0] num,
                                                input logic [9:0] epsr);
        entry_image = {7'b0000000, epsr[7], 14'b00000000000000, epsr[0], num};
    endfunction

    state_t      state_r;
    logic [1:0]  pend_r;
    logic [31:0] set_data_r;
    logic [4:0]  en_apsr_r;
    logic        en_ipsr_r;
    logic        en_epsr_r;
    logic        inst_valid_r;
    logic        exc_done_r;

    logic        idle_s;
    logic        exc_ready_s;
    logic        msr_ready_s;
    logic        alu_ready_s;
    logic        ret_acc_s;
    logic        ent_acc_s;
    logic        exc_acc_s;
    logic        msr_acc_s;
    logic        alu_acc_s;
    logic        wr_s;
    logic        retire_ready_s;
    logic        retire_acc_s;

    logic [31:0] cmd_data_s;
    logic [4:0]  cmd_en_apsr_s;
    logic        cmd_en_ipsr_s;
    logic        cmd_en_epsr_s;
    logic [1:0]  pend_nxt_s;
    logic        inst_valid_nxt_s;

    // Fixed-priority arbitration: exc_ret > exc_ent > msr > alu, IDLE only.
    always_comb begin
        idle_s         = (state_r == ST_IDLE);
        exc_ready_s    = idle_s;
        msr_ready_s    = idle_s & ~exc_ent_valid & ~exc_ret_valid;
        alu_ready_s    = msr_ready_s & ~msr_valid;
        ret_acc_s      = idle_s & exc_ret_valid;
        ent_acc_s      = idle_s & exc_ent_valid & ~exc_ret_valid;
        exc_acc_s      = ret_acc_s | ent_acc_s;
        msr_acc_s      = msr_ready_s & msr_valid;
        alu_acc_s      = alu_ready_s & alu_valid;
        wr_s           = exc_acc_s | msr_acc_s | alu_acc_s;
        // A full counter can still absorb a retire in a write-free IDLE cycle,
        // because that retire is issued directly rather than deferred.
        retire_ready_s = (pend_r != PEND_MAX_C) | (~wr_s & idle_s);
        retire_acc_s   = retire & retire_ready_s;
    end

    // Select the command image and enables for the winning request.
    always_comb begin
        cmd_data_s    = 32'h0000_0000;
        cmd_en_apsr_s = 5'b00000;
        cmd_en_ipsr_s = 1'b0;
        cmd_en_epsr_s = 1'b0;
        if (ret_acc_s) begin
            cmd_data_s    = stacked_psr;
            cmd_en_apsr_s = 5'b11111;
            cmd_en_ipsr_s = 1'b1;
            cmd_en_epsr_s = 1'b1;
        end else if (ent_acc_s) begin
            cmd_data_s    = entry_image(exc_num, cur_epsr);
            cmd_en_ipsr_s = 1'b1;
            cmd_en_epsr_s = 1'b1;
        end else if (msr_acc_s) begin
            cmd_data_s    = msr_data;
            cmd_en_apsr_s = {5{msr_mask[2]}};
            cmd_en_ipsr_s = msr_mask[1];
            cmd_en_epsr_s = msr_mask[0];
        end else if (alu_acc_s) begin
            cmd_data_s    = {alu_flags, 27'h000_0000};
            cmd_en_apsr_s = alu_mask;
        end else begin
            cmd_data_s    = set_data_r;
        end
    end

    // Deferred-retire bookkeeping and next IT-advance strobe.
    always_comb begin
        pend_nxt_s       = pend_r;
        inst_valid_nxt_s = 1'b0;
        if (exc_acc_s) begin
            // Exceptions discard any outstanding retires, including this one.
            pend_nxt_s = 2'd0;
        end else if (!idle_s) begin
            // Bubble cycle: counter stays empty and retires are dropped.
            pend_nxt_s = 2'd0;
        end else if (wr_s) begin
            if (retire_acc_s) begin
                pend_nxt_s = pend_r + 2'd1;
            end else begin
                pend_nxt_s = pend_r;
            end
        end else begin
            inst_valid_nxt_s = retire | (pend_r != 2'd0);
            if (retire) begin
                // New retire goes out now; backlog is unchanged.
                pend_nxt_s = pend_r;
            end else if (pend_r != 2'd0) begin
                pend_nxt_s = pend_r - 2'd1;
            end else begin
                pend_nxt_s = pend_r;
            end
        end
    end

    // FSM: one-cycle bubble after any accepted exception entry/return.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (exc_acc_s) begin
                        state_r <= ST_EXC_BUB;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXC_BUB: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Registered command stage and deferred-retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r       <= 2'd0;
            set_data_r   <= 32'h0000_0000;
            en_apsr_r    <= 5'b00000;
            en_ipsr_r    <= 1'b0;
            en_epsr_r    <= 1'b0;
            inst_valid_r <= 1'b0;
            exc_done_r   <= 1'b0;
        end else begin
            pend_r       <= pend_nxt_s;
            set_data_r   <= cmd_data_s;
            en_apsr_r    <= cmd_en_apsr_s;
            en_ipsr_r    <= cmd_en_ipsr_s;
            en_epsr_r    <= cmd_en_epsr_s;
            inst_valid_r <= inst_valid_nxt_s;
            exc_done_r   <= exc_acc_s;
        end
    end

    assign exc_ready    = exc_ready_s;
    assign msr_ready    = msr_ready_s;
    assign alu_ready    = alu_ready_s;
    assign retire_ready = retire_ready_s;
    assign set_data     = set_data_r;
    assign en_apsr      = en_apsr_r;
    assign en_ipsr      = en_ipsr_r;
    assign en_epsr      = en_epsr_r;
    assign inst_valid   = inst_valid_r;
    assign exc_done     = exc_done_r;

endmodule

// File: tb/tb_xpsr_wr_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for xpsr_wr_ctrl. Inputs change 1 ns after the
// rising edge; registered outputs are read at that point, combinational
// readies 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_xpsr_wr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_flags;
    logic [4:0]  alu_mask;
    logic        alu_ready;
    logic        msr_valid;
    logic [31:0] msr_data;
    logic [2:0]  msr_mask;
    logic        msr_ready;
    logic        exc_ent_valid;
    logic [8:0]  exc_num;
    logic [9:0]  cur_epsr;
    logic        exc_ret_valid;
    logic [31:0] stacked_psr;
    logic        exc_ready;
    logic        exc_done;
    logic        retire;
    logic        retire_ready;
    logic [31:0] set_data;
    logic [4:0]  en_apsr;
    logic        en_ipsr;
    logic        en_epsr;
    logic        inst_valid;

    int check_cnt;
    int fail_cnt;

    xpsr_wr_ctrl #(.PEND_MAX(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_flags     (alu_flags),
        .alu_mask      (alu_mask),
        .alu_ready     (alu_ready),
        .msr_valid     (msr_valid),
        .msr_data      (msr_data),
        .msr_mask      (msr_mask),
        .msr_ready     (msr_ready),
        .exc_ent_valid (exc_ent_valid),
        .exc_num       (exc_num),
        .cur_epsr      (cur_epsr),
        .exc_ret_valid (exc_ret_valid),
        .stacked_psr   (stacked_psr),
        .exc_ready     (exc_ready),
        .exc_done      (exc_done),
        .retire        (retire),
        .retire_ready  (retire_ready),
        .set_data      (set_data),
        .en_apsr       (en_apsr),
        .en_ipsr       (en_ipsr),
        .en_epsr       (en_epsr),
        .inst_valid    (inst_valid)
    );

    // 100 MHz core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (obs !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid     = 1'b0;
        msr_valid     = 1'b0;
        exc_ent_valid = 1'b0;
        exc_ret_valid = 1'b0;
        retire        = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en_apsr"}, {27'd0, en_apsr}, 32'd0);
        chk({tag, "_en_ipsr"}, {31'd0, en_ipsr}, 32'd0);
        chk({tag, "_en_epsr"}, {31'd0, en_epsr}, 32'd0);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_exc_done"}, {31'd0, exc_done}, 32'd0);
    endtask

    // Invariant and retire-protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv_en_and_iv", {31'd0, ((en_apsr != 5'd0) | en_ipsr | en_epsr) & inst_valid}, 32'd0);
            chk("retire_protocol", {31'd0, retire & ~retire_ready}, 32'd0);
        end
    end

    initial begin
        check_cnt   = 0;
        fail_cnt    = 0;
        rst_n       = 1'b0;
        alu_flags   = 5'b00000;
        alu_mask    = 5'b00000;
        msr_data    = 32'h0000_0000;
        msr_mask    = 3'b000;
        exc_num     = 9'h000;
        cur_epsr    = 10'h000;
        stacked_psr = 32'h0000_0000;
        idle_inputs();

        // ---------------- Reset state ----------------
        tick();
        tick();
        chk("rst_set_data", set_data, 32'h0000_0000);
        chk_quiet("rst");
        rst_n = 1'b1;
        #1;
        chk("rst_exc_ready", {31'd0, exc_ready}, 32'd1);
        chk("rst_msr_ready", {31'd0, msr_ready}, 32'd1);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_retire_ready", {31'd0, retire_ready}, 32'd1);

        // ---------------- Lone ALU update ----------------
        alu_valid = 1'b1;
        alu_flags = 5'b10100;
        alu_mask  = 5'b11110;
        #1;
        chk("alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("alu_flags", {27'd0, set_data[31:27]}, 32'h14);
        chk("alu_en_apsr", {27'd0, en_apsr}, 32'h1E);
        chk("alu_en_ipsr", {31'd0, en_ipsr}, 32'd0);
        chk("alu_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_quiet("alu_after");
        chk("alu_hold", {27'd0, set_data[31:27]}, 32'h14);

        // ---------------- Lone retire ----------------
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk("lone_retire_iv", {31'd0, inst_valid}, 32'd1);
        chk("lone_retire_en", {27'd0, en_apsr}, 32'd0);
        tick();
        chk("lone_retire_done", {31'd0, inst_valid}, 32'd0);

        // ---------------- Collision and replay ----------------
        alu_valid = 1'b1;
        alu_flags = 5'b01011;
        alu_mask  = 5'b11111;
        retire    = 1'b1;
        tick();
        idle_inputs();
        chk("coll_en_apsr", {27'd0, en_apsr}, 32'h1F);
        chk("coll_iv", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("coll_replay_iv", {31'd0, inst_valid}, 32'd1);
        chk("coll_replay_en", {27'd0, en_apsr}, 32'd0);
        tick();
        chk("coll_drained", {31'd0, inst_valid}, 32'd0);

        // ---------------- Counter saturation ----------------
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_flags = 5'(i);
            alu_mask  = 5'b00001;
            retire    = 1'b0;
            #1;
            if (i < 3) begin
                chk("sat_rr_high", {31'd0, retire_ready}, 32'd1);
                retire = 1'b1;
            end else begin
                chk("sat_rr_low", {31'd0, retire_ready}, 32'd0);
            end
            tick();
        end
        idle_inputs();
        chk("sat_last_en", {27'd0, en_apsr}, 32'h01);
        chk("sat_last_iv", {31'd0, inst_valid}, 32'd0);
        #1;
        chk("sat_rr_idle_full", {31'd0, retire_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_replay_iv", {31'd0, inst_valid}, 32'd1);
        end
        tick();
        chk("sat_replay_end", {31'd0, inst_valid}, 32'd0);

        // ---------------- Simultaneous requests ----------------
        exc_ent_valid = 1'b1;
        exc_num       = 9'h00F;
        cur_epsr      = 10'b11_1_101010_1;
        msr_valid     = 1'b1;
        msr_data      = 32'h1234_5678;
        msr_mask      = 3'b111;
        alu_valid     = 1'b1;
        alu_flags     = 5'b11111;
        alu_mask      = 5'b11111;
        #1;
        chk("sim_exc_ready", {31'd0, exc_ready}, 32'd1);
        chk("sim_msr_ready", {31'd0, msr_ready}, 32'd0);
        chk("sim_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        exc_ent_valid = 1'b0;
        chk("ent_set_data", set_data, 32'h0100_020F);
        chk("ent_en_apsr", {27'd0, en_apsr}, 32'd0);
        chk("ent_en_ipsr", {31'd0, en_ipsr}, 32'd1);
        chk("ent_en_epsr", {31'd0, en_epsr}, 32'd1);
        chk("ent_exc_done", {31'd0, exc_done}, 32'd1);
        chk("ent_iv", {31'd0, inst_valid}, 32'd0);
        #1;
        chk("bub_exc_ready", {31'd0, exc_ready}, 32'd0);
        chk("bub_msr_ready", {31'd0, msr_ready}, 32'd0);
        chk("bub_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        chk_quiet("post_bub");
        chk("post_bub_msr_ready", {31'd0, msr_ready}, 32'd1);
        chk("post_bub_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        msr_valid = 1'b0;
        chk("msr_set_data", set_data, 32'h1234_5678);
        chk("msr_en_apsr", {27'd0, en_apsr}, 32'h1F);
        chk("msr_en_ipsr", {31'd0, en_ipsr}, 32'd1);
        chk("msr_en_epsr", {31'd0, en_epsr}, 32'd1);
        #1;
        chk("after_msr_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("sim_alu_flags", {27'd0, set_data[31:27]}, 32'h1F);
        chk("sim_alu_en_apsr", {27'd0, en_apsr}, 32'h1F);
        chk("sim_alu_en_ipsr", {31'd0, en_ipsr}, 32'd0);

        // ---------------- Partial MSR mask ----------------
        msr_valid = 1'b1;
        msr_data  = 32'h0000_01A5;
        msr_mask  = 3'b010;
        tick();
        msr_valid = 1'b0;
        chk("msr_ipsr_only_data", set_data, 32'h0000_01A5);
        chk("msr_ipsr_only_apsr", {27'd0, en_apsr}, 32'd0);
        chk("msr_ipsr_only_ipsr", {31'd0, en_ipsr}, 32'd1);
        chk("msr_ipsr_only_epsr", {31'd0, en_epsr}, 32'd0);
        tick();

        // ---------------- Exception return flush ----------------
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1'b1;
            alu_flags = 5'b00110;
            alu_mask  = 5'b00010;
            retire    = 1'b1;
            tick();
        end
        alu_valid     = 1'b0;
        exc_ret_valid = 1'b1;
        stacked_psr   = 32'hF100_0003;
        retire        = 1'b1;
        tick();
        exc_ret_valid = 1'b0;
        chk("ret_set_data", set_data, 32'hF100_0003);
        chk("ret_en_apsr", {27'd0, en_apsr}, 32'h1F);
        chk("ret_en_ipsr", {31'd0, en_ipsr}, 32'd1);
        chk("ret_en_epsr", {31'd0, en_epsr}, 32'd1);
        chk("ret_exc_done", {31'd0, exc_done}, 32'd1);
        chk("ret_iv", {31'd0, inst_valid}, 32'd0);
        tick();
        retire = 1'b0;
        chk("ret_bub_iv", {31'd0, inst_valid}, 32'd0);
        chk("ret_bub_done", {31'd0, exc_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ret_flushed_iv", {31'd0, inst_valid}, 32'd0);
        end

        // ---------------- Reset during EXC_BUB ----------------
        alu_valid = 1'b1;
        alu_flags = 5'b10001;
        alu_mask  = 5'b10001;
        retire    = 1'b1;
        tick();
        idle_inputs();
        exc_ent_valid = 1'b1;
        exc_num       = 9'h1FF;
        tick();
        exc_ent_valid = 1'b0;
        rst_n         = 1'b0;
        tick();
        chk("rstmid_set_data", set_data, 32'h0000_0000);
        chk_quiet("rstmid");
        rst_n = 1'b1;
        #1;
        chk("rstmid_exc_ready", {31'd0, exc_ready}, 32'd1);
        chk("rstmid_msr_ready", {31'd0, msr_ready}, 32'd1);
        chk("rstmid_alu_ready", {31'd0, alu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_done", {31'd0, exc_done}, 32'd0);
            chk("rstmid_iv", {31'd0, inst_valid}, 32'd0);
        end

        // ---------------- Reset with pending retire ----------------
        alu_valid = 1'b1;
        alu_flags = 5'b00001;
        alu_mask  = 5'b00001;
        retire    = 1'b1;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rstpend_iv", {31'd0, inst_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
